// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared types for the decode1 issue scoreboard
package riscv_pipe_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = $clog2(NUM_REGS);

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     wen;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_RUN,
        SB_FLUSH,
        SB_DRAIN
    } sb_state_e;

endpackage

// File: rtl/sb_hazard_cam.sv
// rtl/sb_hazard_cam.sv - DEPTH-way RAW compare of issuing sources against pending rd
module sb_hazard_cam
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  reg_idx_t              rs1_i,
    input  reg_idx_t              rs2_i,
    input  logic                  use_rs1_i,
    input  logic                  use_rs2_i,
    input  logic [DEPTH-1:0]      bypass_mask_i,
    output logic                  hazard_o
);

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            // x0 is hardwired, so a pending write to it never blocks a reader
            if (entries_i[i].valid && entries_i[i].wen && (entries_i[i].rd != '0) &&
                !bypass_mask_i[i] &&
                ((use_rs1_i && (entries_i[i].rd == rs1_i)) ||
                 (use_rs2_i && (entries_i[i].rd == rs2_i)))) begin
                hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order in-flight write queue gating decode issue; WB_BYPASS_EN lets the retiring entry skip the hazard check
module issue_scoreboard
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  reg_idx_t         issue_rs1,
    input  reg_idx_t         issue_rs2,
    input  logic             issue_use_rs1,
    input  logic             issue_use_rs2,
    input  reg_idx_t         issue_rd,
    input  logic             issue_wen,
    input  logic             issue_serialize,
    output logic             issue_grant,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             wb_valid,
    input  reg_idx_t         wb_rd,
    input  logic             flush_valid,
    input  logic [TAG_W-1:0] flush_tag,
    output logic             squash_decode,
    output logic [TAG_W:0]   occupancy,
    output logic             err
);

    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    sb_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [TAG_W:0]        head_q, head_d, tail_q, tail_d;
    sb_state_e             state_q, state_d;
    logic                  err_q, err_d;

    logic [TAG_W-1:0] head_idx, tail_idx, flush_off;
    logic             empty, full, hazard, grant;
    logic             wb_ok, flush_ok;
    logic [DEPTH-1:0] bypass_mask;

    assign head_idx  = head_q[TAG_W-1:0];
    assign tail_idx  = tail_q[TAG_W-1:0];
    assign occupancy = tail_q - head_q;
    assign empty     = (occupancy == '0);
    assign full      = (occupancy == (TAG_W+1)'(DEPTH));

    assign wb_ok     = wb_valid && !empty &&
                       (!ent_q[head_idx].wen || (wb_rd == ent_q[head_idx].rd));
    assign flush_ok  = flush_valid && ent_q[flush_tag].valid;
    assign flush_off = flush_tag - head_idx;

`ifdef WB_BYPASS_EN
    assign bypass_mask = wb_ok ? ({{(DEPTH-1){1'b0}}, 1'b1} << head_idx) : '0;
`else
    assign bypass_mask = '0;
`endif

    sb_hazard_cam #(.DEPTH(DEPTH)) u_cam (
        .entries_i     (ent_q),
        .rs1_i         (issue_rs1),
        .rs2_i         (issue_rs2),
        .use_rs1_i     (issue_use_rs1),
        .use_rs2_i     (issue_use_rs2),
        .bypass_mask_i (bypass_mask),
        .hazard_o      (hazard)
    );

    always_comb begin
        state_d       = state_q;
        grant         = 1'b0;
        squash_decode = 1'b0;
        case (state_q)
            SB_RUN: begin
                grant = issue_valid && !hazard && !full && !flush_valid &&
                        !(issue_serialize && !empty);
                if (flush_valid)
                    state_d = SB_FLUSH;
                else if (issue_valid && issue_serialize && !empty)
                    state_d = SB_DRAIN;
            end
            SB_DRAIN: begin
                if (flush_valid)
                    state_d = SB_FLUSH;
                else if (empty)
                    state_d = SB_RUN;
            end
            SB_FLUSH: begin
                squash_decode = 1'b1;
                state_d       = flush_valid ? SB_FLUSH : SB_RUN;
            end
            default: state_d = SB_RUN;
        endcase
    end

    // Outputs must read zero while reset is held, even with issue_valid high
    assign issue_grant = grant && reset_n;
    assign issue_tag   = tail_idx;
    assign err         = err_q;

    always_comb begin
        logic [TAG_W-1:0] off_i;
        head_d = head_q;
        tail_d = tail_q;
        ent_d  = ent_q;
        err_d  = err_q || (wb_valid && !wb_ok) || (flush_valid && !flush_ok);
        off_i  = '0;
        if (wb_ok) begin
            ent_d[head_idx].valid = 1'b0;
            head_d                = head_q + PTR_ONE;
        end
        // Offset from the pre-retire head keeps the new tail inside (head, tail]
        if (flush_ok) begin
            tail_d = head_q + {1'b0, flush_off} + PTR_ONE;
            for (int i = 0; i < DEPTH; i++) begin
                off_i = TAG_W'(i) - head_idx;
                if (off_i > flush_off)
                    ent_d[i].valid = 1'b0;
            end
        end else if (grant) begin
            ent_d[tail_idx] = '{valid: 1'b1, rd: issue_rd, wen: issue_wen};
            tail_d          = tail_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            state_q <= SB_RUN;
            err_q   <= 1'b0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed bench for issue_scoreboard (DEPTH=4)
module tb_issue_scoreboard;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       issue_valid, issue_use_rs1, issue_use_rs2, issue_wen, issue_serialize;
    logic [4:0] issue_rs1, issue_rs2, issue_rd, wb_rd;
    logic       issue_grant, wb_valid, flush_valid, squash_decode, err;
    logic [1:0] issue_tag, flush_tag;
    logic [2:0] occupancy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    issue_scoreboard #(.DEPTH(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .issue_valid     (issue_valid),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_use_rs1   (issue_use_rs1),
        .issue_use_rs2   (issue_use_rs2),
        .issue_rd        (issue_rd),
        .issue_wen       (issue_wen),
        .issue_serialize (issue_serialize),
        .issue_grant     (issue_grant),
        .issue_tag       (issue_tag),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .flush_valid     (flush_valid),
        .flush_tag       (flush_tag),
        .squash_decode   (squash_decode),
        .occupancy       (occupancy),
        .err             (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_use_rs1 = 0; issue_use_rs2 = 0;
        issue_rd = 0; issue_wen = 0; issue_serialize = 0;
        wb_valid = 0; wb_rd = 0; flush_valid = 0; flush_tag = 0;
    endtask

    task automatic iss(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic wen, input logic ser);
        issue_valid = 1; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
        issue_use_rs1 = u1; issue_use_rs2 = u2; issue_wen = wen; issue_serialize = ser;
    endtask

    task automatic reset_dut();
        clr();
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
    endtask

    initial begin
        clr();
        reset_n = 0;
        issue_valid = 1;
        #2;
        check_val("rst_occ",    32'(occupancy),     0);
        check_val("rst_grant",  32'(issue_grant),   0);
        check_val("rst_err",    32'(err),           0);
        check_val("rst_squash", 32'(squash_decode), 0);
        tick();
        reset_n = 1;
        clr();

        // RAW: add x5; add x6,x5,x1 stalls until wb x5
        iss(5, 1, 2, 1, 1, 1, 0); #1;
        check_val("raw_first_grant", 32'(issue_grant), 1);
        check_val("raw_first_tag",   32'(issue_tag),   0);
        tick();
        iss(6, 5, 1, 1, 1, 1, 0); #1;
        check_val("raw_stall", 32'(issue_grant), 0);
        tick();
        check_val("raw_stall2", 32'(issue_grant), 0);
        wb_valid = 1; wb_rd = 5; #1;
`ifdef WB_BYPASS_EN
        check_val("raw_wb_grant", 32'(issue_grant), 1);
        check_val("raw_wb_tag",   32'(issue_tag),   1);
        tick();
        clr();
`else
        check_val("raw_wb_grant", 32'(issue_grant), 0);
        tick();
        wb_valid = 0; #1;
        check_val("raw_next_grant", 32'(issue_grant), 1);
        check_val("raw_next_tag",   32'(issue_tag),   1);
        tick();
        clr();
`endif
        #1;
        check_val("raw_occ", 32'(occupancy), 1);
        wb_valid = 1; wb_rd = 6;
        tick();
        clr(); #1;
        check_val("raw_drained", 32'(occupancy), 0);

        // Full queue: tail starts at index 2 here
        for (int k = 0; k < 4; k++) begin
            iss(5'(k + 1), 0, 0, 0, 0, 1, 0); #1;
            check_val("full_fill_grant", 32'(issue_grant), 1);
            check_val("full_fill_tag",   32'(issue_tag),   32'((2 + k) % 4));
            tick();
        end
        iss(7, 0, 0, 0, 0, 1, 0); #1;
        check_val("full_occ",   32'(occupancy),   4);
        check_val("full_block", 32'(issue_grant), 0);
        wb_valid = 1; wb_rd = 1; #1;
        check_val("full_wb_same", 32'(issue_grant), 0);
        tick();
        wb_valid = 0; #1;
        check_val("full_wb_next",     32'(issue_grant), 1);
        check_val("full_wb_next_tag", 32'(issue_tag),   2);
        tick();
        clr(); #1;
        check_val("full_refill_occ", 32'(occupancy), 4);
        check_val("full_err",        32'(err),       0);

        // Flush at tag 1 with tags 0..3 in flight
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            iss(5'(k + 1), 0, 0, 0, 0, 1, 0); #1;
            check_val("fl_tag", 32'(issue_tag), 32'(k));
            tick();
        end
        iss(9, 0, 0, 0, 0, 1, 0);
        flush_valid = 1; flush_tag = 1; #1;
        check_val("flush_beats_issue", 32'(issue_grant), 0);
        tick();
        flush_valid = 0; #1;
        check_val("flush_occ",    32'(occupancy),     2);
        check_val("flush_squash", 32'(squash_decode), 1);
        check_val("flush_bubble", 32'(issue_grant),   0);
        tick();
        check_val("flush_squash_off", 32'(squash_decode), 0);
        check_val("flush_next_grant", 32'(issue_grant),   1);
        check_val("flush_next_tag",   32'(issue_tag),     2);
        tick();
        clr();

        // ecall with two pending writes, then flush during a second drain
        reset_dut();
        iss(1, 0, 0, 0, 0, 1, 0); tick();
        iss(2, 0, 0, 0, 0, 1, 0); tick();
        iss(0, 0, 0, 0, 0, 0, 1); #1;
        check_val("ecall_occ",   32'(occupancy),   2);
        check_val("ecall_stall", 32'(issue_grant), 0);
        tick();
        wb_valid = 1; wb_rd = 1; #1;
        check_val("drain_wb1", 32'(issue_grant), 0);
        tick();
        wb_rd = 2; #1;
        check_val("drain_wb2", 32'(issue_grant), 0);
        tick();
        wb_valid = 0; #1;
        check_val("drain_empty_occ",   32'(occupancy),   0);
        check_val("drain_empty_grant", 32'(issue_grant), 0);
        tick();
        check_val("ecall_grant", 32'(issue_grant), 1);
        check_val("ecall_tag",   32'(issue_tag),   2);
        tick();
        check_val("ecall2_stall", 32'(issue_grant), 0);
        tick();
        flush_valid = 1; flush_tag = 2; #1;
        check_val("drain_flush_grant", 32'(issue_grant), 0);
        tick();
        clr(); #1;
        check_val("drain_flush_squash", 32'(squash_decode), 1);
        check_val("drain_flush_occ",    32'(occupancy),     1);
        check_val("drain_flush_err",    32'(err),           0);

        // x0 never hazards; wb on empty queue flags err
        reset_dut();
        iss(0, 0, 0, 0, 0, 1, 0); tick();
        iss(3, 0, 0, 1, 1, 1, 0); #1;
        check_val("x0_no_stall", 32'(issue_grant), 1);
        tick();
        clr(); #1;
        check_val("x0_occ", 32'(occupancy), 2);
        reset_dut();
        wb_valid = 1; wb_rd = 3;
        tick();
        wb_valid = 0; #1;
        check_val("wb_empty_err", 32'(err),       1);
        check_val("wb_empty_occ", 32'(occupancy), 0);
        check_val("wb_empty_tag", 32'(issue_tag), 0);
        tick();
        check_val("err_sticky", 32'(err), 1);

        // Reset asserted mid-drain with three entries
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            iss(5'(k + 1), 0, 0, 0, 0, 1, 0); tick();
        end
        iss(0, 0, 0, 0, 0, 0, 1); tick();
        iss(4, 0, 0, 0, 0, 1, 0); #1;
        check_val("mid_drain_occ",  32'(occupancy),   3);
        check_val("mid_drain_hold", 32'(issue_grant), 0);
        reset_n = 0; #1;
        check_val("rst_mid_occ",    32'(occupancy),     0);
        check_val("rst_mid_grant",  32'(issue_grant),   0);
        check_val("rst_mid_squash", 32'(squash_decode), 0);
        tick();
        reset_n = 1; #1;
        check_val("post_rst_run_grant", 32'(issue_grant), 1);
        check_val("post_rst_tag",       32'(issue_tag),   0);
        clr();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
